debug_unit: RTL and testbench

- Host-side controller that sits directly downstream of the MIPS pipeline top.
- Consumes the pipeline's debug outputs: PC, register read-out, memory read-out and halt flag.
- Drives the pipeline's debug inputs: run enable, debug flag and debug address.
- Takes single-byte commands from a UART receiver, runs or single-steps the CPU, then streams PC, register file and data-memory contents byte-by-byte to a UART transmitter.

---
 rtl/debug_unit.sv | 168 ++++++++++++++++
 tb/tb_debug_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/debug_unit.sv
// Host-side debug controller for the MIPS pipeline. It runs or single-steps the CPU on UART
// commands, then streams the PC, register file and data memory out MSB-first, byte by byte.
module debug_unit #(
    parameter int LEN            = 32,
    parameter int N_REGS         = 32,
    parameter int N_MEM_WORDS    = 32,
    parameter int MEM_ADDR_SHIFT = 2
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [7:0]     rx_data,
    input  logic           rx_done,
    input  logic           tx_done,
    output logic           tx_start,
    output logic [7:0]     tx_data,
    input  logic [LEN-1:0] in_pc,
    input  logic [LEN-1:0] in_reg_data,
    input  logic [LEN-1:0] in_mem_data,
    input  logic           in_halt_flag,
    output logic           out_cpu_enable,
    output logic           out_debug_flag,
    output logic [LEN-1:0] out_addr_debug
);
    localparam int RW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int MW = (N_MEM_WORDS > 1) ? $clog2(N_MEM_WORDS) : 1;
    localparam logic [RW-1:0] REG_LAST = RW'(N_REGS - 1);
    localparam logic [MW-1:0] MEM_LAST = MW'(N_MEM_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RUN, S_STEP, S_DUMP_PC, S_SEND, S_WAIT_TX, S_SET_ADDR, S_WAIT_RD, S_LOAD
    } state_t;
    typedef enum logic [1:0] {W_PC, W_REG, W_MEM} word_t;

    state_t          state_q, state_d;
    word_t           phase_q, phase_d;
    logic [RW-1:0]   reg_idx_q, reg_idx_d;
    logic [MW-1:0]   mem_idx_q, mem_idx_d;
    logic [1:0]      byte_q, byte_d;
    logic [LEN-1:0]  shift_q, shift_d;
    logic [LEN-1:0]  addr_q, addr_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            tx_start_q, tx_start_d;
    logic            en_q, en_d;
    logic            dbg_q, dbg_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            phase_q    <= W_PC;
            reg_idx_q  <= '0;
            mem_idx_q  <= '0;
            byte_q     <= '0;
            shift_q    <= '0;
            addr_q     <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            en_q       <= 1'b0;
            dbg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            reg_idx_q  <= reg_idx_d;
            mem_idx_q  <= mem_idx_d;
            byte_q     <= byte_d;
            shift_q    <= shift_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            en_q       <= en_d;
            dbg_q      <= dbg_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        reg_idx_d  = reg_idx_q;
        mem_idx_d  = mem_idx_q;
        byte_d     = byte_q;
        shift_d    = shift_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        en_d       = en_q;
        dbg_d      = dbg_q;
        case (state_q)
            S_IDLE: begin
                if (rx_done && (rx_data == 8'h63 || rx_data == 8'h73)) begin
                    if (in_halt_flag) begin
                        state_d = S_DUMP_PC;
                    end else begin
                        en_d    = 1'b1;
                        state_d = (rx_data == 8'h63) ? S_RUN : S_STEP;
                    end
                end
            end
            S_RUN: begin
                if (in_halt_flag || (rx_done && rx_data == 8'h70)) begin
                    en_d    = 1'b0;
                    state_d = S_DUMP_PC;
                end
            end
            S_STEP: begin
                en_d    = 1'b0;
                state_d = S_DUMP_PC;
            end
            S_DUMP_PC: begin
                shift_d   = in_pc;
                dbg_d     = 1'b1;
                byte_d    = '0;
                phase_d   = W_PC;
                reg_idx_d = '0;
                mem_idx_d = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                tx_data_d  = shift_q[LEN-1 -: 8];
                tx_start_d = 1'b1;
                state_d    = S_WAIT_TX;
            end
            S_WAIT_TX: begin
                if (tx_done) begin
                    shift_d = shift_q << 8;
                    byte_d  = byte_q + 2'd1;
                    if (byte_q != 2'd3) begin
                        state_d = S_SEND;
                    end else begin
                        // Word finished: pick the next word; the last memory word ends the dump.
                        state_d = S_SET_ADDR;
                        case (phase_q)
                            W_PC:  phase_d = W_REG;
                            W_REG: begin
                                if (reg_idx_q == REG_LAST) phase_d = W_MEM;
                                else reg_idx_d = reg_idx_q + 1'b1;
                            end
                            default: begin
                                if (mem_idx_q == MEM_LAST) begin
                                    dbg_d   = 1'b0;
                                    addr_d  = '0;
                                    state_d = S_IDLE;
                                end else begin
                                    mem_idx_d = mem_idx_q + 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            S_SET_ADDR: begin
                addr_d  = (phase_q == W_REG) ? LEN'(reg_idx_q)
                                             : (LEN'(mem_idx_q) << MEM_ADDR_SHIFT);
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: state_d = S_LOAD;
            S_LOAD: begin
                shift_d = (phase_q == W_REG) ? in_reg_data : in_mem_data;
                state_d = S_SEND;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign tx_start       = tx_start_q;
    assign tx_data        = tx_data_q;
    assign out_cpu_enable = en_q;
    assign out_debug_flag = dbg_q;
    assign out_addr_debug = addr_q;
endmodule

// File: tb/tb_debug_unit.sv
// Bench for debug_unit: a CPU/UART environment model plus a byte-stream reference built
// directly from the dump order (PC, registers, memory), with randomized CPU contents.
module tb_debug_unit;
    localparam int NR = 32;
    localparam int NM = 32;
    localparam int NB = 4 * (1 + NR + NM);

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_done;
    logic        tb_txd;
    logic        txm_done = 1'b0;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [31:0] pc;
    logic [31:0] in_reg_data, in_mem_data;
    logic        in_halt_flag;
    logic        out_cpu_enable, out_debug_flag;
    logic [31:0] out_addr_debug;
    logic [31:0] regs[NR];
    logic [31:0] mems[NM];

    always #5 clk = ~clk;

    assign tx_done     = tb_txd | txm_done;
    assign in_reg_data = regs[out_addr_debug[4:0]];
    assign in_mem_data = mems[out_addr_debug[6:2]];

    debug_unit #(.LEN(32), .N_REGS(NR), .N_MEM_WORDS(NM), .MEM_ADDR_SHIFT(2)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .tx_done(tx_done),
        .tx_start(tx_start), .tx_data(tx_data), .in_pc(pc), .in_reg_data(in_reg_data),
        .in_mem_data(in_mem_data), .in_halt_flag(in_halt_flag), .out_cpu_enable(out_cpu_enable),
        .out_debug_flag(out_debug_flag), .out_addr_debug(out_addr_debug)
    );

    // Transmitter model: captures each started byte with the debug address/flag at that moment.
    logic [7:0]  cap_b[$];
    logic [31:0] cap_a[$];
    logic        cap_f[$];
    int en_cnt = 0, overlap = 0, busy = 0, dly = 0;

    always @(negedge clk) begin
        txm_done = 1'b0;
        if (out_cpu_enable) en_cnt++;
        if (!reset) begin
            busy = 0;
        end else if (tx_start) begin
            if (busy != 0) overlap++;
            cap_b.push_back(tx_data);
            cap_a.push_back(out_addr_debug);
            cap_f.push_back(out_debug_flag);
            busy = 1;
            dly  = $urandom_range(0, 3);
        end else if (busy != 0) begin
            if (dly == 0) begin
                txm_done = 1'b1;
                busy     = 0;
            end else begin
                dly--;
            end
        end
    end

    int vectors = 0, miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int w);
        if (w == 0) return pc;
        else if (w <= NR) return regs[w-1];
        else return mems[w-1-NR];
    endfunction

    function automatic logic [31:0] exp_addr(input int w);
        if (w == 0) return 32'd0;
        else if (w <= NR) return 32'(w - 1);
        else return 32'((w - 1 - NR) * 4);
    endfunction

    task automatic randomize_cpu();
        pc = $urandom;
        for (int k = 0; k < NR; k++) regs[k] = $urandom;
        for (int k = 0; k < NM; k++) mems[k] = $urandom;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
    endtask

    task automatic wait_bytes(input int base, input int n);
        int t = 0;
        while (cap_b.size() < base + n && t < 6000) begin
            @(negedge clk);
            t++;
        end
        if (cap_b.size() < base + n) check("timeout", 32'(cap_b.size() - base), 32'(n));
    endtask

    task automatic check_dump(input string tag, input int base);
        logic [31:0] w;
        int got;
        wait_bytes(base, NB);
        repeat (20) @(negedge clk);
        got = cap_b.size() - base;
        check({tag, "_count"}, 32'(got), 32'(NB));
        for (int b = 0; b < NB && b < got; b++) begin
            w = exp_word(b / 4);
            check($sformatf("%s_byte%0d", tag, b), 32'(cap_b[base+b]), 32'(w[31-8*(b%4) -: 8]));
            check($sformatf("%s_addr%0d", tag, b), cap_a[base+b], exp_addr(b / 4));
            check($sformatf("%s_flag%0d", tag, b), 32'(cap_f[base+b]), 32'd1);
        end
        check({tag, "_flag_end"}, 32'(out_debug_flag), 32'd0);
        check({tag, "_addr_end"}, out_addr_debug, 32'd0);
        check({tag, "_en_end"}, 32'(out_cpu_enable), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'd0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        check({tag, "_en"}, 32'(out_cpu_enable), 32'd0);
        check({tag, "_flag"}, 32'(out_debug_flag), 32'd0);
        check({tag, "_addr"}, out_addr_debug, 32'd0);
    endtask

    initial begin
        int base, en0;
        reset = 1'b0; rx_done = 1'b0; rx_data = 8'h00; tb_txd = 1'b0; in_halt_flag = 1'b0;
        pc = 32'h0000_0004;
        for (int k = 0; k < NR; k++) regs[k] = 32'h100 + 32'(k);
        for (int k = 0; k < NM; k++) mems[k] = 32'hA000_0000 + 32'(k);

        // Reset held with stray command and tx_done pulses.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rx_data = 8'h63; rx_done = (i % 2 == 0); tb_txd = (i % 2 == 1);
            #1 check_all_zero($sformatf("reset%0d", i));
        end
        @(negedge clk);
        rx_done = 1'b0; tb_txd = 1'b0; reset = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_no_tx", 32'(cap_b.size()), 32'd0);
        check_all_zero("idle");

        // Single step with fixed contents.
        base = cap_b.size(); en0 = en_cnt;
        send_byte(8'h73);
        check_dump("step", base);
        check("step_en", 32'(en_cnt - en0), 32'd1);

        // Run until halt raised 50 cycles later.
        randomize_cpu();
        base = cap_b.size(); en0 = en_cnt;
        send_byte(8'h63);
        repeat (50) @(negedge clk);
        in_halt_flag = 1'b1;
        check_dump("halt", base);
        check("halt_en", 32'(en_cnt - en0), 32'd51);
        in_halt_flag = 1'b0;

        // Run then pause with 'p'.
        randomize_cpu();
        base = cap_b.size(); en0 = en_cnt;
        send_byte(8'h63);
        repeat (10) @(negedge clk);
        send_byte(8'h70);
        check_dump("pause", base);
        check("pause_en", 32'(en_cnt - en0), 32'd11);

        // Unknown command is ignored.
        base = cap_b.size(); en0 = en_cnt;
        send_byte(8'h41);
        repeat (30) @(negedge clk);
        check("ign_bytes", 32'(cap_b.size() - base), 32'd0);
        check("ign_en", 32'(en_cnt - en0), 32'd0);
        check("ign_flag", 32'(out_debug_flag), 32'd0);

        // 's' arriving mid-dump must not disturb the stream.
        randomize_cpu();
        base = cap_b.size(); en0 = en_cnt;
        send_byte(8'h73);
        wait_bytes(base, 100);
        send_byte(8'h73);
        check_dump("middump_s", base);
        check("middump_s_en", 32'(en_cnt - en0), 32'd1);

        // CPU already halted: no enable, dump still sent.
        in_halt_flag = 1'b1;
        randomize_cpu();
        base = cap_b.size(); en0 = en_cnt;
        send_byte(8'h73);
        check_dump("halted", base);
        check("halted_en", 32'(en_cnt - en0), 32'd0);
        in_halt_flag = 1'b0;

        // Reset in the middle of a dump, then a fresh complete dump.
        randomize_cpu();
        base = cap_b.size();
        send_byte(8'h73);
        wait_bytes(base, 37);
        reset = 1'b0;
        #1 check_all_zero("midreset");
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("postreset");
        randomize_cpu();
        base = cap_b.size(); en0 = en_cnt;
        send_byte(8'h73);
        check_dump("after_reset", base);
        check("after_reset_en", 32'(en_cnt - en0), 32'd1);

        check("tx_overlap", 32'(overlap), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
